host_cmd_unpacker: RTL

- Sits directly upstream of OpalKellyEmulatorModuleTop, between the Opal Kelly pipe-in FIFO and the emulator's host-side ports.
- Parses a single 16-bit host word stream into four things:
  - configuration registers (io_host_steps, io_used_procs);
  - two-word instruction beats on the insns decoupled port;
  - one-word input beats on the io_i decoupled port;
  - a sticky error flag for malformed commands.

---
 rtl/host_cmd_unpacker.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/host_cmd_unpacker.sv
// host_cmd_unpacker
//   Turns the 16-bit host word stream from the pipe-in FIFO into the
//   emulator's host-side interface. It has three kinds of output:
//   configuration registers, decoupled instruction beats (two words each,
//   low word first) and decoupled input beats (one word each). It also keeps
//   a sticky flag for headers with an illegal opcode.
//
//   Header word: [15:12] opcode, [11:0] count
//     0x1 SET_STEPS : the next word loads io_host_steps
//     0x2 SET_PROCS : the next word [PROC_W-1:0] loads io_used_procs
//     0x3 INSNS     : count instruction beats follow
//     0x4 INPUTS    : count input beats follow
//     other         : the header is consumed and err is set
//
// Ports
//   clock, reset         single clock; reset is asynchronous and active-low
//   in_valid/ready/bits  host word stream
//   io_host_steps        configured host steps per target cycle
//   io_used_procs        configured processor count
//   io_insns_*           instruction beat (bits_0 = low, bits_1 = high)
//   io_io_i_*            input beat
//   busy                 a command is in flight or an output beat is pending
//   err                  sticky illegal-opcode flag, cleared only by reset
module host_cmd_unpacker #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 12,
    parameter int PROC_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_bits,
    output logic [15:0]       io_host_steps,
    output logic [PROC_W-1:0] io_used_procs,
    output logic              io_insns_valid,
    input  logic              io_insns_ready,
    output logic [WORD_W-1:0] io_insns_bits_0,
    output logic [WORD_W-1:0] io_insns_bits_1,
    output logic              io_io_i_valid,
    input  logic              io_io_i_ready,
    output logic [WORD_W-1:0] io_io_i_bits_0,
    output logic              busy,
    output logic              err
);

    localparam int OP_W = WORD_W - CNT_W;

    localparam logic [OP_W-1:0] OP_SET_STEPS = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SET_PROCS = OP_W'(2);
    localparam logic [OP_W-1:0] OP_INSNS     = OP_W'(3);
    localparam logic [OP_W-1:0] OP_INPUTS    = OP_W'(4);

    typedef enum logic [2:0] {
        IDLE,
        CFG_STEPS,
        CFG_PROCS,
        INS_LO,
        INS_HI,
        INP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    remaining;
    logic [WORD_W-1:0]   ins_lo_hold;
    logic                accept;
    logic [OP_W-1:0]     hdr_op;
    logic [CNT_W-1:0]    hdr_cnt;
    logic                last_beat;

    assign hdr_op    = in_bits[WORD_W-1:CNT_W];
    assign hdr_cnt   = in_bits[CNT_W-1:0];
    assign accept    = in_valid && in_ready;
    // The command ends on this beat when remaining is 1 or less. The
    // decrement below is guarded, so remaining never wraps below zero.
    assign last_beat = (remaining <= CNT_W'(1));

    // A word that completes a beat can be accepted only when the output
    // register is free, or is being emptied in this same cycle. in_ready
    // depends on state, valid and ready, and never on in_valid.
    // NOTE: a default comes first so that every path assigns in_ready and no latch is inferred.
    always_comb begin
        in_ready = 1'b1;
        case (state)
            INS_HI:  in_ready = !io_insns_valid || io_insns_ready;
            INP:     in_ready = !io_io_i_valid || io_io_i_ready;
            default: in_ready = 1'b1;
        endcase
    end

    assign busy = (state != IDLE) || io_insns_valid || io_io_i_valid;

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            remaining       <= '0;
            // NOTE: the holding register is reset as well, so the design never holds X after reset.
            ins_lo_hold     <= '0;
            io_host_steps   <= '0;
            io_used_procs   <= '0;
            io_insns_valid  <= 1'b0;
            io_insns_bits_0 <= '0;
            io_insns_bits_1 <= '0;
            io_io_i_valid   <= 1'b0;
            io_io_i_bits_0  <= '0;
            err             <= 1'b0;
        end else begin
            // Clear valid on a dequeue. A load later in this block overrides
            // the clear, so a dequeue and a load in the same cycle keep
            // valid high with the new data.
            if (io_insns_valid && io_insns_ready) begin
                io_insns_valid <= 1'b0;
            end
            if (io_io_i_valid && io_io_i_ready) begin
                io_io_i_valid <= 1'b0;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        remaining <= hdr_cnt;
                        case (hdr_op)
                            OP_SET_STEPS: state <= CFG_STEPS;
                            OP_SET_PROCS: state <= CFG_PROCS;
                            OP_INSNS:     state <= (hdr_cnt != '0) ? INS_LO : IDLE;
                            OP_INPUTS:    state <= (hdr_cnt != '0) ? INP : IDLE;
                            default:      err   <= 1'b1;
                        endcase
                    end
                    CFG_STEPS: begin
                        io_host_steps <= in_bits;
                        state         <= IDLE;
                    end
                    CFG_PROCS: begin
                        io_used_procs <= in_bits[PROC_W-1:0];
                        state         <= IDLE;
                    end
                    INS_LO: begin
                        ins_lo_hold <= in_bits;
                        state       <= INS_HI;
                    end
                    INS_HI: begin
                        io_insns_bits_0 <= ins_lo_hold;
                        io_insns_bits_1 <= in_bits;
                        io_insns_valid  <= 1'b1;
                        remaining       <= last_beat ? '0 : remaining - CNT_W'(1);
                        state           <= last_beat ? IDLE : INS_LO;
                    end
                    INP: begin
                        io_io_i_bits_0 <= in_bits;
                        io_io_i_valid  <= 1'b1;
                        remaining      <= last_beat ? '0 : remaining - CNT_W'(1);
                        state          <= last_beat ? IDLE : INP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
